// File: rtl/battleship_pkg.sv
// Shared definitions for the battleship game controller.
// Holds the game state enum, board cell codes, the ship limit and small
// helpers for the ship-count clamp and the per-state phase enables.
package battleship_pkg;

  localparam int MAX_SHIPS = 5;

  typedef enum logic [3:0] {
    IDLE,
    SHIP_SELECT,
    PLACE,
    PC_SETUP,
    PLAYER_TURN,
    PC_WAIT,
    PC_TURN,
    VICTORY,
    DEFEAT
  } game_state_t;

  typedef enum logic [1:0] {
    AGUA        = 2'd0,
    BARCO       = 2'd1,
    ATACA_BARCO = 2'd2,
    ATACA_AGUA  = 2'd3
  } cell_t;

  // Requested ship count forced into 1..MAX_SHIPS.
  function automatic logic [2:0] clamp_ships(input logic [2:0] sw);
    if (sw == 3'd0) return 3'd1;
    else if (sw > 3'(MAX_SHIPS)) return 3'(MAX_SHIPS);
    else return sw;
  endfunction

  // Phase enables for a state: {defeat, victory, pc_turn, player_turn, setup, colocation}.
  function automatic logic [5:0] phase_of(input game_state_t s);
    case (s)
      PLACE:       return 6'b000001;
      PC_SETUP:    return 6'b000010;
      PLAYER_TURN: return 6'b000100;
      PC_TURN:     return 6'b001000;
      VICTORY:     return 6'b010000;
      DEFEAT:      return 6'b100000;
      default:     return 6'b000000;
    endcase
  endfunction

endpackage

// File: rtl/battleship_game_ctrl_if.sv
// Board-side signal bundle of the game controller.
// master: controller (drives board reset, ship count, phase enables;
//         receives placement/setup status, move flags and sunk flags).
// slave:  board datapath (the opposite directions).
interface battleship_game_ctrl_if;
  import battleship_pkg::*;

  logic       finished_placing;
  logic       finished_setup;
  logic       player_has_move;
  logic       pc_has_move;
  logic       pc_ships_zero;
  logic       player_ships_zero;
  logic       board_rst_n;
  logic [2:0] ship_amount_define;
  logic       colocation_state;
  logic       setup_state;
  logic       player_turn_state;
  logic       pc_turn_state;
  logic       victory_state;
  logic       defeat_state;

  modport master (
    input  finished_placing, finished_setup, player_has_move, pc_has_move,
           pc_ships_zero, player_ships_zero,
    output board_rst_n, ship_amount_define, colocation_state, setup_state,
           player_turn_state, pc_turn_state, victory_state, defeat_state
  );

  modport slave (
    output finished_placing, finished_setup, player_has_move, pc_has_move,
           pc_ships_zero, player_ships_zero,
    input  board_rst_n, ship_amount_define, colocation_state, setup_state,
           player_turn_state, pc_turn_state, victory_state, defeat_state
  );
endinterface

// File: rtl/turn_timer.sv
// Player-turn countdown.
// Ports: clk, rst (async, active high); load reloads the tick counter to
// CLK_HZ-1 and the seconds counter to TURN_SECONDS; enable lets the counters
// run; seconds_left is the displayed count (0 while disabled); expired is
// high on the cycle the tick counter wraps with one second remaining.
module turn_timer #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int TURN_SECONDS = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       enable,
  output logic [3:0] seconds_left,
  output logic       expired
);
  import battleship_pkg::*;

  localparam int TICK_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(CLK_HZ - 1);
  localparam logic [3:0] SEC_INIT = 4'(TURN_SECONDS);

  logic [TICK_W-1:0] tick_cnt;
  logic [3:0]        sec_cnt;
  logic              tick_wrap;

  assign tick_wrap = (tick_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      sec_cnt  <= '0;
    end else if (load) begin
      tick_cnt <= TICK_MAX;
      sec_cnt  <= SEC_INIT;
    end else if (enable) begin
      if (tick_wrap) begin
        tick_cnt <= TICK_MAX;
        if (sec_cnt != 4'd0) sec_cnt <= sec_cnt - 4'd1;
      end else begin
        tick_cnt <= tick_cnt - TICK_W'(1);
      end
    end
  end

  assign expired      = enable && tick_wrap && (sec_cnt == 4'd1);
  assign seconds_left = enable ? sec_cnt : 4'd0;
endmodule

// File: rtl/battleship_game_ctrl.sv
// Battleship game sequencing controller.
// Ports: clk, rst (async, active high); start_btn / confirm_btn debounced
// levels, rising-edge detected; ship_sw requested ship count; seconds_left
// player-turn countdown for display; timeout_pulse one cycle on turn
// timeout; board: board-side bundle (master modport).
//
// state       | meaning
// IDLE        | waiting for start
// SHIP_SELECT | waiting for confirm to latch the ship count
// PLACE       | player places ships
// PC_SETUP    | PC places ships
// PLAYER_TURN | player attacks, turn timer running
// PC_WAIT     | pause before the PC attack
// PC_TURN     | PC attacks
// VICTORY     | all PC ships sunk, waiting for start
// DEFEAT      | all player ships sunk, waiting for start
module battleship_game_ctrl
  import battleship_pkg::*;
#(
  parameter int CLK_HZ          = 50_000_000,
  parameter int TURN_SECONDS    = 15,
  parameter int PC_DELAY_CYCLES = 25_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_btn,
  input  logic                   confirm_btn,
  input  logic [2:0]             ship_sw,
  output logic [3:0]             seconds_left,
  output logic                   timeout_pulse,
  battleship_game_ctrl_if.master board
);

  localparam int WAIT_W = (PC_DELAY_CYCLES > 1) ? $clog2(PC_DELAY_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_INIT =
    (PC_DELAY_CYCLES > 0) ? WAIT_W'(PC_DELAY_CYCLES - 1) : '0;

  game_state_t       state;
  logic [5:0]        phase_q;
  logic [2:0]        ship_q;
  logic              brst_n_q;
  logic              brst_hold;
  logic [WAIT_W-1:0] wait_cnt;

  // Board flags: {player_ships_zero, pc_ships_zero, pc_has_move, player_has_move}
  logic [3:0] flag_s1, flag_s2;
  logic [1:0] move_q;
  logic       start_q, confirm_q;
  logic       start_evt, confirm_evt;
  logic       player_move_rise, pc_move_rise;
  logic       timer_load, timer_en, timer_expired;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_s1   <= '0;
      flag_s2   <= '0;
      move_q    <= '0;
      start_q   <= 1'b0;
      confirm_q <= 1'b0;
    end else begin
      flag_s1   <= {board.player_ships_zero, board.pc_ships_zero,
                    board.pc_has_move, board.player_has_move};
      flag_s2   <= flag_s1;
      move_q    <= flag_s2[1:0];
      start_q   <= start_btn;
      confirm_q <= confirm_btn;
    end
  end

  assign start_evt        = start_btn & ~start_q;
  assign confirm_evt      = confirm_btn & ~confirm_q;
  assign player_move_rise = flag_s2[0] & ~move_q[0];
  assign pc_move_rise     = flag_s2[1] & ~move_q[1];

  // The timer sits in reload whenever the player is not on turn, so every
  // entry to PLAYER_TURN starts from a full count.
  assign timer_en   = phase_q[2];
  assign timer_load = ~phase_q[2];

  turn_timer #(
    .CLK_HZ      (CLK_HZ),
    .TURN_SECONDS(TURN_SECONDS)
  ) u_turn_timer (
    .clk         (clk),
    .rst         (rst),
    .load        (timer_load),
    .enable      (timer_en),
    .seconds_left(seconds_left),
    .expired     (timer_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      phase_q       <= '0;
      ship_q        <= 3'd1;
      brst_n_q      <= 1'b0;
      brst_hold     <= 1'b0;
      wait_cnt      <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= 1'b0;
      // Second cycle of the board reset after a restart, otherwise released.
      if (brst_hold) begin
        brst_n_q  <= 1'b0;
        brst_hold <= 1'b0;
      end else begin
        brst_n_q <= 1'b1;
      end

      case (state)
        IDLE: if (start_evt) begin
          state   <= SHIP_SELECT;
          phase_q <= phase_of(SHIP_SELECT);
        end
        SHIP_SELECT: if (confirm_evt) begin
          ship_q  <= clamp_ships(ship_sw);
          state   <= PLACE;
          phase_q <= phase_of(PLACE);
        end
        PLACE: if (board.finished_placing) begin
          state   <= PC_SETUP;
          phase_q <= phase_of(PC_SETUP);
        end
        PC_SETUP: if (board.finished_setup) begin
          state   <= PLAYER_TURN;
          phase_q <= phase_of(PLAYER_TURN);
        end
        PLAYER_TURN: begin
          if (flag_s2[2]) begin
            state   <= VICTORY;
            phase_q <= phase_of(VICTORY);
          end else if (player_move_rise || timer_expired) begin
            state         <= PC_WAIT;
            phase_q       <= phase_of(PC_WAIT);
            wait_cnt      <= WAIT_INIT;
            timeout_pulse <= ~player_move_rise;
          end
        end
        PC_WAIT: begin
          if (wait_cnt == '0) begin
            state   <= PC_TURN;
            phase_q <= phase_of(PC_TURN);
          end else begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end
        end
        PC_TURN: begin
          // A simultaneous wipe-out counts as a player win.
          if (flag_s2[3] && flag_s2[2]) begin
            state   <= VICTORY;
            phase_q <= phase_of(VICTORY);
          end else if (flag_s2[3]) begin
            state   <= DEFEAT;
            phase_q <= phase_of(DEFEAT);
          end else if (pc_move_rise) begin
            state   <= PLAYER_TURN;
            phase_q <= phase_of(PLAYER_TURN);
          end
        end
        VICTORY, DEFEAT: if (start_evt) begin
          state     <= IDLE;
          phase_q   <= phase_of(IDLE);
          brst_n_q  <= 1'b0;
          brst_hold <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          phase_q <= '0;
        end
      endcase
    end
  end

  assign board.board_rst_n        = brst_n_q;
  assign board.ship_amount_define = ship_q;
  assign board.colocation_state   = phase_q[0];
  assign board.setup_state        = phase_q[1];
  assign board.player_turn_state  = phase_q[2];
  assign board.pc_turn_state      = phase_q[3];
  assign board.victory_state      = phase_q[4];
  assign board.defeat_state       = phase_q[5];
endmodule

// File: tb/tb_battleship_game_ctrl.sv
module tb_battleship_game_ctrl;
  localparam int CLK_HZ  = 10;
  localparam int TURN_S  = 3;
  localparam int DELAY   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_btn, confirm_btn;
  logic [2:0] ship_sw;
  logic [3:0] seconds_left;
  logic       timeout_pulse;

  battleship_game_ctrl_if bif();

  battleship_game_ctrl #(
    .CLK_HZ(CLK_HZ), .TURN_SECONDS(TURN_S), .PC_DELAY_CYCLES(DELAY)
  ) dut (
    .clk(clk), .rst(rst), .start_btn(start_btn), .confirm_btn(confirm_btn),
    .ship_sw(ship_sw), .seconds_left(seconds_left), .timeout_pulse(timeout_pulse),
    .board(bif.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_SELECT, M_PLACE, M_SETUP, M_PTURN, M_WAIT, M_PCTURN, M_WIN, M_LOSE} mstate_e;
  mstate_e m_st;
  int  m_ship, turn_n, wait_n, low_left;
  bit  m_timeout, m_in_reset;
  bit  [3:0] h1, h2, h3;   // raw flag samples from 1, 2, 3 edges ago
  bit  start_prev, confirm_prev;

  task automatic model_reset();
    m_st = M_IDLE; m_ship = 1; turn_n = 0; wait_n = 0; low_left = 0;
    m_timeout = 0; m_in_reset = 1; h1 = 0; h2 = 0; h3 = 0;
    start_prev = 0; confirm_prev = 0;
  endtask

  task automatic model_step();
    bit [3:0] raw, syn, rise;
    bit st_ev, cf_ev;
    raw  = {bif.player_ships_zero, bif.pc_ships_zero, bif.pc_has_move, bif.player_has_move};
    syn  = h2;
    rise = h2 & ~h3;
    st_ev = start_btn && !start_prev;
    cf_ev = confirm_btn && !confirm_prev;
    m_in_reset = 0;
    m_timeout = 0;
    if (low_left > 0) low_left--;
    case (m_st)
      M_IDLE:   if (st_ev) m_st = M_SELECT;
      M_SELECT: if (cf_ev) begin
        m_ship = (ship_sw < 1) ? 1 : (ship_sw > 5) ? 5 : int'(ship_sw);
        m_st = M_PLACE;
      end
      M_PLACE:  if (bif.finished_placing) m_st = M_SETUP;
      M_SETUP:  if (bif.finished_setup) begin m_st = M_PTURN; turn_n = 0; end
      M_PTURN: begin
        turn_n++;
        if (syn[2]) m_st = M_WIN;
        else if (rise[0]) begin m_st = M_WAIT; wait_n = 0; end
        else if (turn_n == TURN_S * CLK_HZ) begin m_st = M_WAIT; wait_n = 0; m_timeout = 1; end
      end
      M_WAIT: begin
        wait_n++;
        if (wait_n >= ((DELAY > 0) ? DELAY : 1)) m_st = M_PCTURN;
      end
      M_PCTURN: begin
        if (syn[3] && syn[2]) m_st = M_WIN;
        else if (syn[3]) m_st = M_LOSE;
        else if (rise[1]) begin m_st = M_PTURN; turn_n = 0; end
      end
      M_WIN, M_LOSE: if (st_ev) begin m_st = M_IDLE; low_left = 2; end
      default: m_st = M_IDLE;
    endcase
    h3 = h2; h2 = h1; h1 = raw;
    start_prev = start_btn; confirm_prev = confirm_btn;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  task automatic check_all();
    chk("board_rst_n", bif.board_rst_n, (!m_in_reset && low_left == 0) ? 1 : 0);
    chk("ship_amount", bif.ship_amount_define, m_ship);
    chk("colocation_state", bif.colocation_state, m_st == M_PLACE);
    chk("setup_state", bif.setup_state, m_st == M_SETUP);
    chk("player_turn_state", bif.player_turn_state, m_st == M_PTURN);
    chk("pc_turn_state", bif.pc_turn_state, m_st == M_PCTURN);
    chk("victory_state", bif.victory_state, m_st == M_WIN);
    chk("defeat_state", bif.defeat_state, m_st == M_LOSE);
    chk("seconds_left", seconds_left, (m_st == M_PTURN) ? (TURN_S - turn_n / CLK_HZ) : 0);
    chk("timeout_pulse", timeout_pulse, m_timeout);
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    check_all();
  end

  // ---------------- directed helpers ----------------
  function automatic logic sel_sig(input int which);
    case (which)
      0: return bif.colocation_state;
      1: return bif.setup_state;
      2: return bif.player_turn_state;
      3: return bif.pc_turn_state;
      4: return bif.victory_state;
      default: return bif.defeat_state;
    endcase
  endfunction

  task automatic wait_sig(input string name, input int which, input logic level,
                          input int limit, output int n);
    n = 0;
    while (n < limit) begin
      @(posedge clk); #1; n++;
      if (sel_sig(which) == level) return;
    end
    checks++; failures++;
    $display("FAIL %s: no response within %0d cycles", name, limit);
    n = -1;
  endtask

  task automatic press(input int which);
    @(negedge clk);
    if (which == 0) start_btn = 1'b1; else confirm_btn = 1'b1;
    repeat (3) @(negedge clk);
    if (which == 0) start_btn = 1'b0; else confirm_btn = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int n, tcyc, lowcnt;

  initial begin
    start_btn = 0; confirm_btn = 0; ship_sw = 0;
    bif.finished_placing = 0; bif.finished_setup = 0;
    bif.player_has_move = 0; bif.pc_has_move = 0;
    bif.pc_ships_zero = 0; bif.player_ships_zero = 0;

    repeat (3) @(posedge clk); #1;
    chk("rst_ship_amount", bif.ship_amount_define, 1);
    chk("rst_board_rst_n", bif.board_rst_n, 0);
    chk("rst_seconds", seconds_left, 0);
    @(negedge clk) rst = 0;
    @(posedge clk); #1;
    chk("brst_after_release", bif.board_rst_n, 1);

    // Run 1: clamp high, full timeout path
    ship_sw = 3'd7;
    press(0);
    press(1);
    chk("ship_clamp_7", bif.ship_amount_define, 5);
    chk("colocation_on", bif.colocation_state, 1);
    @(negedge clk) bif.finished_placing = 1;
    wait_sig("setup_entry", 1, 1'b1, 10, n);
    @(negedge clk) bif.finished_setup = 1;
    wait_sig("pturn_entry", 2, 1'b1, 10, n);
    chk("pturn_seconds_init", seconds_left, 3);
    tcyc = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (i == 9)  chk("sec_at_9", seconds_left, 3);
      if (i == 10) chk("sec_at_10", seconds_left, 2);
      if (i == 29) chk("sec_at_29", seconds_left, 1);
      if (timeout_pulse) begin tcyc = i; break; end
    end
    chk("timeout_cycle", tcyc, 30);
    wait_sig("pc_turn_after_timeout", 3, 1'b1, 10, n);
    chk("pc_wait_len", n, 4);

    // PC move returns the turn; player moves at cycle 5
    @(negedge clk) bif.pc_has_move = 1;
    wait_sig("pturn_reentry", 2, 1'b1, 10, n);
    chk("reload_seconds", seconds_left, 3);
    repeat (4) @(posedge clk);
    @(negedge clk) begin bif.player_has_move = 1; bif.pc_has_move = 0; end
    wait_sig("pturn_exit_move", 2, 1'b0, 10, n);
    chk("move_exit_cycle", 4 + n, 7);
    wait_sig("pc_turn_after_move", 3, 1'b1, 10, n);
    chk("pc_wait_len_move", n, 4);
    @(negedge clk) begin bif.player_has_move = 0; bif.pc_has_move = 1; end
    wait_sig("pturn_third", 2, 1'b1, 10, n);
    @(negedge clk) bif.pc_has_move = 0;

    // Victory and restart
    @(negedge clk) begin bif.pc_ships_zero = 1; bif.player_has_move = 1; end
    wait_sig("victory_entry", 4, 1'b1, 10, n);
    @(negedge clk) begin
      bif.pc_ships_zero = 0; bif.player_has_move = 0;
      bif.finished_placing = 0; bif.finished_setup = 0;
      start_btn = 1;
    end
    lowcnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (i == 0) chk("brst_low_first", bif.board_rst_n, 0);
      if (!bif.board_rst_n) lowcnt++;
    end
    chk("brst_low_len", lowcnt, 2);
    chk("victory_cleared", bif.victory_state, 0);
    @(negedge clk) start_btn = 0;

    // Run 2: clamp low, reset during PC_WAIT
    ship_sw = 3'd0;
    press(0);
    press(1);
    chk("ship_clamp_0", bif.ship_amount_define, 1);
    @(negedge clk) bif.finished_placing = 1;
    wait_sig("setup_entry2", 1, 1'b1, 10, n);
    @(negedge clk) bif.finished_setup = 1;
    wait_sig("pturn_entry2", 2, 1'b1, 10, n);
    @(negedge clk) bif.player_has_move = 1;
    wait_sig("pturn_exit2", 2, 1'b0, 10, n);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst = 1;
    #1;
    chk("async_rst_brst", bif.board_rst_n, 0);
    chk("async_rst_pturn", bif.player_turn_state, 0);
    chk("async_rst_coloc", bif.colocation_state, 0);
    check_all();
    @(negedge clk) begin
      rst = 0;
      bif.finished_placing = 0; bif.finished_setup = 0; bif.player_has_move = 0;
    end
    @(posedge clk); #1;
    chk("idle_brst_after_rst", bif.board_rst_n, 1);

    // Randomized play against the model
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) start_btn = ~start_btn;
      if ($urandom_range(0, 5) == 0) confirm_btn = ~confirm_btn;
      ship_sw = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) bif.finished_placing = ~bif.finished_placing;
      if ($urandom_range(0, 7) == 0) bif.finished_setup = ~bif.finished_setup;
      if ($urandom_range(0, 4) == 0) bif.player_has_move = ~bif.player_has_move;
      if ($urandom_range(0, 4) == 0) bif.pc_has_move = ~bif.pc_has_move;
      if (bif.pc_ships_zero) bif.pc_ships_zero = ($urandom_range(0, 5) != 0);
      else bif.pc_ships_zero = ($urandom_range(0, 149) == 0);
      if (bif.player_ships_zero) bif.player_ships_zero = ($urandom_range(0, 5) != 0);
      else bif.player_ships_zero = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 699) == 0) begin
        rst = 1;
        @(negedge clk) rst = 0;
      end
    end

    @(posedge clk); #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
